// File: rtl/datapath_step_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer producing one-cycle datapath enables.
// Optional breakpoint support is enabled by defining DATAPATH_STEP_SEQUENCER_BREAKPOINT_EN.
module datapath_step_sequencer #(
  parameter int unsigned          PC_WIDTH    = 9,
  parameter int unsigned          OPCODE_W    = 4,
  parameter logic [OPCODE_W-1:0]  HALT_OPCODE = 4'hF,
  parameter int unsigned          CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step,
  input  logic                halt_req,
  input  logic                resume,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                dec_regwrite,
  input  logic                dec_memwrite,
  input  logic                dec_memtoreg,
  input  logic [PC_WIDTH-1:0] pc,
`ifdef DATAPATH_STEP_SEQUENCER_BREAKPOINT_EN
  input  logic [PC_WIDTH-1:0] bp_addr,
  input  logic                bp_valid,
  output logic                bp_hit,
`endif
  output logic                ir_load,
  output logic                pc_en,
  output logic                reg_we,
  output logic                mem_we,
  output logic                busy,
  output logic                halted,
  output logic [2:0]          phase,
  output logic [CNT_W-1:0]    retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic             step_q, step_d;
  logic             ss_flag_q, ss_flag_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             step_rise;
  logic             bp_cond;

`ifdef DATAPATH_STEP_SEQUENCER_BREAKPOINT_EN
  logic             bp_hit_q, bp_hit_d;

  always_comb begin
    bp_cond = bp_valid && (pc == bp_addr);
  end
`else
  // No breakpoint hardware: pc is only folded in so the port stays referenced.
  always_comb begin
    bp_cond = (^pc) & 1'b0;
  end
`endif

  always_comb begin
    step_d    = step;
    step_rise = step & ~step_q;
  end

  always_comb begin
    state_d   = state_q;
    ss_flag_d = ss_flag_q;
    retired_d = retired_q;
`ifdef DATAPATH_STEP_SEQUENCER_BREAKPOINT_EN
    bp_hit_d  = bp_hit_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (!halt_req) begin
          if (run) begin
            state_d   = S_FETCH;
            ss_flag_d = 1'b0;
          end else if (step_rise) begin
            state_d   = S_FETCH;
            ss_flag_d = 1'b1;
          end
        end
      end
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC:   state_d = (dec_memwrite || dec_memtoreg) ? S_MEM : S_WB;
      S_MEM:    state_d = S_WB;
      S_WB: begin
        if (retired_q != '1) begin
          retired_d = retired_q + 1'b1;
        end
        // The instruction always retires here; the halt sources only pick the next state.
        if (opcode == HALT_OPCODE) begin
          state_d   = S_HALT;
          ss_flag_d = 1'b0;
        end else if (bp_cond) begin
          state_d   = S_HALT;
          ss_flag_d = 1'b0;
`ifdef DATAPATH_STEP_SEQUENCER_BREAKPOINT_EN
          bp_hit_d  = 1'b1;
`endif
        end else if (halt_req) begin
          state_d   = S_HALT;
          ss_flag_d = 1'b0;
        end else if (ss_flag_q || !run) begin
          state_d   = S_IDLE;
          ss_flag_d = 1'b0;
        end else begin
          state_d   = S_FETCH;
        end
      end
      S_HALT: begin
        if (resume) begin
          state_d  = S_IDLE;
`ifdef DATAPATH_STEP_SEQUENCER_BREAKPOINT_EN
          bp_hit_d = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      step_q    <= 1'b0;
      ss_flag_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      ss_flag_q <= ss_flag_d;
      retired_q <= retired_d;
    end
  end

`ifdef DATAPATH_STEP_SEQUENCER_BREAKPOINT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_d;
    end
  end

  always_comb begin
    bp_hit = bp_hit_q;
  end
`endif

  // Enables decode from the state register alone, so reset removes them asynchronously.
  always_comb begin
    ir_load = (state_q == S_FETCH);
    pc_en   = (state_q == S_WB);
    reg_we  = (state_q == S_WB) && dec_regwrite;
    mem_we  = (state_q == S_MEM) && dec_memwrite;
    busy    = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC) ||
              (state_q == S_MEM) || (state_q == S_WB);
    halted  = (state_q == S_HALT);
    phase   = state_q;
    retired = retired_q;
  end

endmodule

// File: tb/tb_datapath_step_sequencer.sv
// Scoreboard bench: per-cycle expected outputs are queued with the stimulus and compared one cycle at a time.
module tb_datapath_step_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0, step = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic        dec_regwrite = 1'b0, dec_memwrite = 1'b0, dec_memtoreg = 1'b0;
  logic [8:0]  pc = '0;
  logic        ir_load, pc_en, reg_we, mem_we, busy, halted;
  logic [2:0]  phase;
  logic [15:0] retired;
`ifdef DATAPATH_STEP_SEQUENCER_BREAKPOINT_EN
  logic [8:0]  bp_addr = '0;
  logic        bp_valid = 1'b0;
  logic        bp_hit;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] sb_q[$];
  logic [15:0] exp_ret;
  string       scen;

  always #5 clk = ~clk;

  datapath_step_sequencer #(
    .PC_WIDTH(9), .OPCODE_W(4), .HALT_OPCODE(4'hF), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
    .resume(resume), .opcode(opcode), .dec_regwrite(dec_regwrite),
    .dec_memwrite(dec_memwrite), .dec_memtoreg(dec_memtoreg), .pc(pc),
`ifdef DATAPATH_STEP_SEQUENCER_BREAKPOINT_EN
    .bp_addr(bp_addr), .bp_valid(bp_valid), .bp_hit(bp_hit),
`endif
    .ir_load(ir_load), .pc_en(pc_en), .reg_we(reg_we), .mem_we(mem_we),
    .busy(busy), .halted(halted), .phase(phase), .retired(retired)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] obs();
    return {7'b0, phase, ir_load, pc_en, reg_we, mem_we, busy, halted, retired};
  endfunction

  // Expected packed outputs for a given phase, as the phase table defines them.
  function automatic logic [31:0] mk(input int ph, input bit rw, input bit mw, input logic [15:0] ret);
    logic [2:0] p;
    p = ph[2:0];
    return {7'b0, p, (ph == 1), (ph == 5), ((ph == 5) && rw), ((ph == 4) && mw),
            ((ph >= 1) && (ph <= 5)), (ph == 6), ret};
  endfunction

  task automatic push(input int ph, input bit rw, input bit mw);
    sb_q.push_back(mk(ph, rw, mw, exp_ret));
    if (ph == 5) exp_ret++;
  endtask

  task automatic push_instr(input bit mem_op, input bit rw, input bit mw);
    push(1, rw, mw); push(2, rw, mw); push(3, rw, mw);
    if (mem_op) push(4, rw, mw);
    push(5, rw, mw);
  endtask

  task automatic drain();
    logic [31:0] e;
    while (sb_q.size() > 0) begin
      @(posedge clk); #1;
      e = sb_q.pop_front();
      check(scen, obs(), e);
    end
  endtask

  task automatic do_reset();
    run = 0; step = 0; halt_req = 0; resume = 0; opcode = 4'h0; pc = '0;
    dec_regwrite = 0; dec_memwrite = 0; dec_memtoreg = 0;
    reset = 0;
    #1 check("reset", obs(), mk(0, 0, 0, 16'd0));
    @(posedge clk); #1;
    reset = 1;
    exp_ret = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    do_reset();

    scen = "alu_run";
    run = 1; dec_regwrite = 1;
    push_instr(0, 1, 0); push_instr(0, 1, 0);
    drain();
    run = 0;
    push(0, 1, 0); drain();

    scen = "store_run";
    run = 1; dec_regwrite = 0; dec_memwrite = 1;
    push_instr(1, 0, 1);
    drain();
    run = 0;
    push(0, 0, 1); drain();

    scen = "load_run";
    run = 1; dec_regwrite = 1; dec_memwrite = 0; dec_memtoreg = 1;
    push_instr(1, 1, 0);
    drain();
    run = 0;
    push(0, 1, 0); drain();

    do_reset();
    scen = "single_step";
    dec_regwrite = 1;
    for (int k = 0; k < 3; k++) begin
      step = 1;
      push_instr(0, 1, 0);
      for (int i = 0; i < 6; i++) push(0, 1, 0);
      drain();
      step = 0;
      push(0, 1, 0); drain();
    end
    check("step_retired", {16'd0, retired}, 32'd3);
    scen = "step_busy_edge";
    step = 1; push(1, 1, 0); drain();
    step = 0; push(2, 1, 0); drain();
    step = 1;
    push(3, 1, 0); push(5, 1, 0);
    for (int i = 0; i < 4; i++) push(0, 1, 0);
    drain();
    step = 0;

    do_reset();
    scen = "halt_opcode";
    run = 1; dec_regwrite = 1;
    push_instr(0, 1, 0); push_instr(0, 1, 0); push(1, 1, 0);
    drain();
    opcode = 4'hF;
    push(2, 1, 0); push(3, 1, 0); push(5, 1, 0);
    for (int i = 0; i < 4; i++) push(6, 1, 0);
    drain();
    check("halt_retired", {16'd0, retired}, 32'd3);
    scen = "halt_resume";
    step = 1; push(6, 1, 0); drain();
    step = 0;
    resume = 1; opcode = 4'h0;
    push(0, 1, 0); drain();
    resume = 0;
    push(1, 1, 0); drain();

    do_reset();
    scen = "halt_req";
    run = 1; dec_regwrite = 1;
    push(1, 1, 0); push(2, 1, 0); drain();
    halt_req = 1;
    push(3, 1, 0); push(5, 1, 0); push(6, 1, 0); push(6, 1, 0);
    drain();
    scen = "halt_req_idle";
    resume = 1; push(0, 1, 0); drain();
    resume = 0;
    push(0, 1, 0); push(0, 1, 0); drain();
    halt_req = 0;
    push(1, 1, 0); drain();

    do_reset();
    scen = "reset_in_mem";
    run = 1; dec_memwrite = 1;
    push_instr(1, 0, 1);
    push(1, 0, 1); push(2, 0, 1); push(3, 0, 1); push(4, 0, 1);
    drain();
    reset = 0;
    #1 check("reset_mid_mem", obs(), mk(0, 0, 0, 16'd0));
    @(posedge clk); #1;
    run = 0; dec_memwrite = 0;
    reset = 1;
    exp_ret = '0;

`ifdef DATAPATH_STEP_SEQUENCER_BREAKPOINT_EN
    do_reset();
    scen = "breakpoint";
    bp_addr = 9'h005; bp_valid = 1; run = 1; dec_regwrite = 1;
    push(1, 1, 0); drain();
    for (int k = 0; k < 3; k++) begin
      pc = 9'(3 + k);
      push(2, 1, 0); push(3, 1, 0); push(5, 1, 0);
      if (k < 2) push(1, 1, 0);
      else begin push(6, 1, 0); push(6, 1, 0); end
      drain();
    end
    check("bp_hit_set", {31'd0, bp_hit}, 32'd1);
    check("bp_retired", {16'd0, retired}, 32'd3);
    run = 0; resume = 1;
    push(0, 1, 0); drain();
    resume = 0;
    check("bp_hit_clear", {31'd0, bp_hit}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
